sorted_run_merger: RTL and testbench

Two-way merge stage directly downstream of the merge sorter control unit and batcher network. Consumes two ascending-sorted runs, the A and B streams, and emits one ascending-sorted run of length len_a+len_b on a registered AXI-stream output. It is the building block of the merge tree that joins batcher-sorted chunks of 8 or fewer elements into the final sorted sequence. Run lengths are latched at start; input tlast is ignored.

---
 rtl/merge_sorter_pkg.sv | 21 ++
 rtl/merge_key_compare.sv | 17 +
 rtl/sorted_run_merger.sv | 160 ++++++++++++++++
 tb/tb_sorted_run_merger.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_sorter_pkg.sv
// Shared types and constants for the merge sorter datapath: merger FSM states,
// batcher chunk size and the run-length counter width helper.
package merge_sorter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    DRAIN_A,
    DRAIN_B,
    FLUSH,
    DONE
  } merger_state_t;

  localparam int unsigned BATCH_SIZE = 8;

  // Counter must hold the full length value MAX, hence one extra bit.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/merge_key_compare.sv
// Key comparator for the two-way merge; selects A when a_key <= b_key.
// SORTED_RUN_MERGER_SIGNED_COMPARE_EN switches to two's-complement ordering.
module merge_key_compare #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a_key,
  input  logic [DATA_WIDTH-1:0] i_b_key,
  output logic                  o_select_a
);

`ifdef SORTED_RUN_MERGER_SIGNED_COMPARE_EN
  assign o_select_a = ($signed(i_a_key) <= $signed(i_b_key));
`else
  assign o_select_a = (i_a_key <= i_b_key);
`endif

endmodule

// File: rtl/sorted_run_merger.sv
// Two-way stable merge of ascending runs A and B into one registered output stream.
// Key ordering is signed when SORTED_RUN_MERGER_SIGNED_COMPARE_EN is defined.
module sorted_run_merger #(
  parameter int          DATA_WIDTH      = 16,
  parameter int          DEST_WIDTH      = 16,
  parameter int          USER_WIDTH      = 16,
  parameter int unsigned MAX_SORT_LENGTH = 256
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [$clog2(MAX_SORT_LENGTH):0] len_a,
  input  logic [$clog2(MAX_SORT_LENGTH):0] len_b,
  input  logic [DATA_WIDTH-1:0]            in_a_data,
  input  logic [DEST_WIDTH-1:0]            in_a_dest,
  input  logic [USER_WIDTH-1:0]            in_a_user,
  input  logic                             in_a_valid,
  output logic                             in_a_ready,
  input  logic [DATA_WIDTH-1:0]            in_b_data,
  input  logic [DEST_WIDTH-1:0]            in_b_dest,
  input  logic [USER_WIDTH-1:0]            in_b_user,
  input  logic                             in_b_valid,
  output logic                             in_b_ready,
  output logic [DATA_WIDTH-1:0]            merged_data,
  output logic [DEST_WIDTH-1:0]            merged_dest,
  output logic [USER_WIDTH-1:0]            merged_user,
  output logic                             merged_valid,
  input  logic                             merged_ready,
  output logic                             merged_tlast,
  output logic                             busy,
  output logic                             done
);
  import merge_sorter_pkg::*;

  localparam int unsigned       LW      = len_width(MAX_SORT_LENGTH);
  localparam logic [LW-1:0]     LEN_ONE = LW'(1);

  merger_state_t         r_state;
  merger_state_t         w_next_state;
  logic [LW-1:0]         r_rem_a;
  logic [LW-1:0]         r_rem_b;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_valid;
  logic                  r_tlast;

  logic w_slot_free;
  logic w_sel_a;
  logic w_a_hs;
  logic w_b_hs;
  logic w_a_last;
  logic w_b_last;
  logic w_load_last;

  merge_key_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .i_a_key    (in_a_data),
    .i_b_key    (in_b_data),
    .o_select_a (w_sel_a)
  );

  assign w_slot_free = ~r_valid | merged_ready;
  assign w_a_hs      = in_a_valid & in_a_ready;
  assign w_b_hs      = in_b_valid & in_b_ready;
  assign w_a_last    = (r_rem_a == LEN_ONE);
  assign w_b_last    = (r_rem_b == LEN_ONE);
  // The element that empties both counters closes the merged run.
  assign w_load_last = (w_a_hs & w_a_last & (r_rem_b == '0)) |
                       (w_b_hs & w_b_last & (r_rem_a == '0));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len_a == '0 && len_b == '0) w_next_state = DONE;
          else if (len_a == '0)           w_next_state = DRAIN_B;
          else if (len_b == '0)           w_next_state = DRAIN_A;
          else                            w_next_state = MERGE;
        end
      end
      MERGE: begin
        if (w_a_hs && w_a_last)      w_next_state = (r_rem_b == '0) ? FLUSH : DRAIN_B;
        else if (w_b_hs && w_b_last) w_next_state = (r_rem_a == '0) ? FLUSH : DRAIN_A;
      end
      DRAIN_A: if (w_a_hs && w_a_last) w_next_state = FLUSH;
      DRAIN_B: if (w_b_hs && w_b_last) w_next_state = FLUSH;
      FLUSH:   if (r_valid && merged_ready) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_a_ready = 1'b0;
    in_b_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      MERGE: begin
        in_a_ready = in_a_valid & in_b_valid & w_slot_free &  w_sel_a;
        in_b_ready = in_a_valid & in_b_valid & w_slot_free & ~w_sel_a;
        busy       = 1'b1;
      end
      DRAIN_A: begin
        in_a_ready = w_slot_free;
        busy       = 1'b1;
      end
      DRAIN_B: begin
        in_b_ready = w_slot_free;
        busy       = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem_a <= '0;
      r_rem_b <= '0;
      r_data  <= '0;
      r_dest  <= '0;
      r_user  <= '0;
      r_valid <= 1'b0;
      r_tlast <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_rem_a <= len_a;
        r_rem_b <= len_b;
      end else begin
        if (w_a_hs) r_rem_a <= r_rem_a - LEN_ONE;
        if (w_b_hs) r_rem_b <= r_rem_b - LEN_ONE;
      end
      if (w_a_hs || w_b_hs) begin
        r_valid <= 1'b1;
        r_data  <= w_a_hs ? in_a_data : in_b_data;
        r_dest  <= w_a_hs ? in_a_dest : in_b_dest;
        r_user  <= w_a_hs ? in_a_user : in_b_user;
        r_tlast <= w_load_last;
      end else if (merged_ready) begin
        r_valid <= 1'b0;
        r_tlast <= 1'b0;
      end
    end
  end

  assign merged_data  = r_data;
  assign merged_dest  = r_dest;
  assign merged_user  = r_user;
  assign merged_valid = r_valid;
  assign merged_tlast = r_tlast;

endmodule

// File: tb/tb_sorted_run_merger.sv
// Randomized self-checking bench for sorted_run_merger; the expected stream is a
// stable sort of A-then-B elements, with ordering following SORTED_RUN_MERGER_SIGNED_COMPARE_EN.
module tb_sorted_run_merger;
  localparam int DW   = 16;
  localparam int TW   = 16;
  localparam int UW   = 16;
  localparam int MAXL = 256;
  localparam int LW   = $clog2(MAXL) + 1;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [LW-1:0] len_a, len_b;
  logic [DW-1:0] in_a_data, in_b_data, merged_data;
  logic [TW-1:0] in_a_dest, in_b_dest, merged_dest;
  logic [UW-1:0] in_a_user, in_b_user, merged_user;
  logic          in_a_valid, in_a_ready, in_b_valid, in_b_ready;
  logic          merged_valid, merged_ready, merged_tlast, busy, done;

  sorted_run_merger #(
    .DATA_WIDTH(DW), .DEST_WIDTH(TW), .USER_WIDTH(UW), .MAX_SORT_LENGTH(MAXL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .len_a(len_a), .len_b(len_b),
    .in_a_data(in_a_data), .in_a_dest(in_a_dest), .in_a_user(in_a_user),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_b_data(in_b_data), .in_b_dest(in_b_dest), .in_b_user(in_b_user),
    .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
    .merged_data(merged_data), .merged_dest(merged_dest), .merged_user(merged_user),
    .merged_valid(merged_valid), .merged_ready(merged_ready), .merged_tlast(merged_tlast),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef logic [15:0] kq_t[$];
  typedef struct packed {
    logic [15:0] key;
    logic [15:0] dest;
    logic [15:0] user;
  } elem_t;

  int    n_checks = 0;
  int    n_errors = 0;
  kq_t   a_key, b_key, a_dst, b_dst;
  elem_t exp_q[$];
  bit    abort_req;
  bit    exact;
  int    gap_pct, stall_pct;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit key_le(input logic [15:0] x, input logic [15:0] y);
`ifdef SORTED_RUN_MERGER_SIGNED_COMPARE_EN
    return $signed(x) <= $signed(y);
`else
    return x <= y;
`endif
  endfunction

  function automatic kq_t sorted_rand(input int n, input logic [15:0] mask);
    kq_t q;
    logic [15:0] v;
    int j;
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom) & mask;
      j = q.size();
      while (j > 0 && !key_le(q[j-1], v)) j--;
      q.insert(j, v);
    end
    return q;
  endfunction

  function automatic void rand_dests();
    a_dst.delete();
    b_dst.delete();
    foreach (a_key[i]) a_dst.push_back(16'($urandom));
    foreach (b_key[i]) b_dst.push_back(16'($urandom));
  endfunction

  // Stable insertion sort of all A elements followed by all B elements.
  function automatic void build_expected();
    elem_t all[$];
    exp_q.delete();
    foreach (a_key[i]) all.push_back('{a_key[i], a_dst[i], 16'(i)});
    foreach (b_key[i]) all.push_back('{b_key[i], b_dst[i], 16'h8000 | 16'(i)});
    foreach (all[i]) begin
      int j;
      j = exp_q.size();
      while (j > 0 && !key_le(exp_q[j-1].key, all[i].key)) j--;
      exp_q.insert(j, all[i]);
    end
  endfunction

  task automatic drive(input bit is_b);
    int i = 0;
    int guard = 0;
    int n;
    n = is_b ? b_key.size() : a_key.size();
    while (i < n && !abort_req && guard < 3000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        if (is_b) in_b_valid = 1'b0; else in_a_valid = 1'b0;
      end else if (is_b) begin
        in_b_valid = 1'b1; in_b_data = b_key[i]; in_b_dest = b_dst[i]; in_b_user = 16'h8000 | 16'(i);
      end else begin
        in_a_valid = 1'b1; in_a_data = a_key[i]; in_a_dest = a_dst[i]; in_a_user = 16'(i);
      end
      @(negedge clock);
      if (is_b ? (in_b_valid && in_b_ready) : (in_a_valid && in_a_ready)) i++;
      @(posedge clock); #1;
      guard++;
    end
    if (is_b) in_b_valid = 1'b0; else in_a_valid = 1'b0;
  endtask

  task automatic monitor(input int abort_after);
    int n, k, a_cnt, b_cnt, cyc, first_hs, last_hs;
    bit got_done, stalled;
    logic [48:0] held;
    n = exp_q.size();
    k = 0; a_cnt = 0; b_cnt = 0; cyc = 0; first_hs = -1; last_hs = -1;
    got_done = 0; stalled = 0; held = '0;
    while (!got_done && !abort_req && cyc < 3000) begin
      @(negedge clock);
      if (in_a_ready && (b_key.size() - b_cnt) > 0) check("a_rdy_needs_b_valid", in_b_valid, 1'b1);
      if (in_b_ready && (a_key.size() - a_cnt) > 0) check("b_rdy_needs_a_valid", in_a_valid, 1'b1);
      if (in_a_valid && in_a_ready) a_cnt++;
      if (in_b_valid && in_b_ready) b_cnt++;
      if (stalled) begin
        check("stall_valid", merged_valid, 1'b1);
        check("stall_hold", {merged_data, merged_dest, merged_user, merged_tlast}, held);
      end
      if (merged_valid && merged_ready) begin
        check("out_in_range", (k < n), 1'b1);
        if (k < n) begin
          check("out_data", merged_data, exp_q[k].key);
          check("out_dest", merged_dest, exp_q[k].dest);
          check("out_user", merged_user, exp_q[k].user);
          check("out_tlast", merged_tlast, (k == n - 1));
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        k++;
      end
      stalled = merged_valid && !merged_ready;
      held    = {merged_data, merged_dest, merged_user, merged_tlast};
      if (done) begin
        got_done = 1;
        check("done_count", k, n);
        check("done_time", cyc, (n > 0) ? last_hs + 1 : 1);
        check("busy_at_done", busy, 1'b0);
      end
      if (abort_after > 0 && k == abort_after) abort_req = 1;
      @(posedge clock); #1;
      start = 1'b0;
      merged_ready = (int'($urandom_range(99)) >= stall_pct);
      cyc++;
    end
    check("finished_in_time", got_done | abort_req, 1'b1);
    if (got_done && exact && n > 0) check("throughput", last_hs - first_hs, n - 1);
  endtask

  task automatic run_case(input bit ex, input int gp, input int st, input int abort_after);
    rand_dests();
    build_expected();
    exact = ex; gap_pct = gp; stall_pct = st; abort_req = 0;
    check("idle_no_valid", merged_valid, 1'b0);
    len_a = LW'(a_key.size());
    len_b = LW'(b_key.size());
    start = 1'b1;
    merged_ready = (int'($urandom_range(99)) >= st);
    fork
      drive(1'b0);
      drive(1'b1);
      monitor(abort_after);
    join
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len_a = '0; len_b = '0; merged_ready = 1'b0;
    in_a_valid = 1'b0; in_a_data = '0; in_a_dest = '0; in_a_user = '0;
    in_b_valid = 1'b0; in_b_data = '0; in_b_dest = '0; in_b_user = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", merged_valid, 1'b0);
    check("rst_tlast", merged_tlast, 1'b0);
    check("rst_data", {merged_data, merged_dest, merged_user}, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", {in_a_ready, in_b_ready}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    a_key = '{16'd1, 16'd3, 16'd5, 16'd7}; b_key = '{16'd2, 16'd4, 16'd6, 16'd8};
    run_case(1, 0, 0, 0);
    a_key = '{16'd5, 16'd5, 16'd9}; b_key = '{16'd5, 16'd6};
    run_case(1, 0, 0, 0);
    a_key = {}; b_key = '{16'd2, 16'd4, 16'd6};
    run_case(1, 0, 0, 0);
    a_key = {}; b_key = {};
    run_case(1, 0, 0, 0);
    a_key = '{16'hFFFF}; b_key = '{16'h0001};
    run_case(1, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      a_key = sorted_rand(8, (t % 2 == 0) ? 16'h000F : 16'hFFFF);
      b_key = sorted_rand(8, (t % 2 == 0) ? 16'h000F : 16'hFFFF);
      run_case(0, 30, 30, 0);
    end

    a_key = sorted_rand(8, 16'h00FF); b_key = sorted_rand(8, 16'h00FF);
    run_case(0, 0, 0, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("abort_valid", merged_valid, 1'b0);
    check("abort_tlast", merged_tlast, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    a_key = sorted_rand(2, 16'h00FF); b_key = sorted_rand(2, 16'h00FF);
    run_case(1, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      a_key = sorted_rand(int'($urandom_range(8)), 16'h001F);
      b_key = sorted_rand(int'($urandom_range(8)), 16'h001F);
      run_case(0, 20, 40, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
